// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux channel multiplexer.
// Mode codes, output-stage state type and select-width helper.
package stream_mux_pkg;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle between N input channels and one output stream.
// The select width follows the channel count and is not a free parameter.
interface stream_mux_if #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4
);
  import stream_mux_pkg::*;

  localparam int SELW = sel_width(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      ctrl_sel;
  logic [WIDTH-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [SELW-1:0]      out_ch;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    output ctrl_sel,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_ch
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    input  ctrl_sel,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_ch
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin request search starting just past the previous grant.
// Purely combinational; the caller owns the last_grant register.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = sel_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last_grant,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int off = 1; off <= NCH; off++) begin
      if (!grant_valid &&
          req[(int'(last_grant) + off) % NCH]) begin
        grant       = SELW'((int'(last_grant) + off) % NCH);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer with a one-entry registered output stage.
// Channel choice is either an external select or round-robin.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_SELECT
) (
  input logic         clk,
  input logic         rst_n,
  stream_mux_if.slave bus
);

  localparam int SELW = sel_width(NCH);

  ostate_t          state;
  ostate_t          state_n;
  logic [SELW-1:0]  g;
  logic             gv;
  logic             load_en;
  logic             take;
  logic [NCH-1:0]   rdy;
  logic [WIDTH-1:0] data_q;
  logic [SELW-1:0]  ch_q;

  assign load_en = (state == EMPTY) || bus.out_ready;
  assign take    = rst_n && load_en && gv;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] last_grant;
      logic            unused_sel;

      assign unused_sel = ^bus.ctrl_sel;

      rr_arbiter #(
        .NCH(NCH)
      ) u_arb (
        .req        (bus.in_valid),
        .last_grant (last_grant),
        .grant      (g),
        .grant_valid(gv)
      );

      // Reset to the top channel so the first search starts at 0
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          last_grant <= SELW'(NCH - 1);
        end else if (take) begin
          last_grant <= g;
        end
      end
    end else begin : g_sel
      always_comb begin
        g = bus.ctrl_sel;
        if (int'(bus.ctrl_sel) >= NCH) begin
          g = '0;
        end
        gv = bus.in_valid[g];
      end
    end
  endgenerate

  always_comb begin
    rdy = '0;
    if (take) begin
      rdy[g] = 1'b1;
    end
  end

  assign bus.in_ready = rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      EMPTY: begin
        if (take) begin
          state_n = FULL;
        end
      end
      FULL: begin
        if (bus.out_ready && !take) begin
          state_n = EMPTY;
        end
      end
      default: state_n = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ch_q   <= '0;
    end else if (take) begin
      data_q <= bus.in_data[int'(g)*WIDTH +: WIDTH];
      ch_q   <= g;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign bus.out_valid = (state == FULL);

endmodule

// File: tb/tb_stream_mux.sv
// Randomized and directed bench for stream_mux in three configurations.
// A spec-level cycle model predicts grants, ready and output register.
module tb_stream_mux;
  import stream_mux_pkg::*;

  localparam int W  = 8;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  stream_mux_if #(.WIDTH(W), .NCH(4)) b0();
  stream_mux_if #(.WIDTH(W), .NCH(4)) b1();
  stream_mux_if #(.WIDTH(W), .NCH(3)) b2();

  stream_mux #(.WIDTH(W), .NCH(4), .MODE(MODE_SELECT)) u_sel (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  stream_mux #(.WIDTH(W), .NCH(4), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  stream_mux #(.WIDTH(W), .NCH(3), .MODE(MODE_SELECT)) u_n3 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] din [NI][4];
  logic [3:0] vin [NI];
  logic [1:0] sel [NI];
  logic       ordy[NI];

  int mv[NI];
  int md[NI];
  int mc[NI];
  int ml[NI];

  function automatic int nch(int k);
    return (k == 2) ? 3 : 4;
  endfunction

  function automatic bit is_rr(int k);
    return k == 1;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] obs(int k, int f);
    logic [31:0] r;
    r = '0;
    case (k)
      0: case (f)
           0: r = 32'(b0.out_valid);
           1: r = 32'(b0.out_data);
           2: r = 32'(b0.out_ch);
           default: r = 32'(b0.in_ready);
         endcase
      1: case (f)
           0: r = 32'(b1.out_valid);
           1: r = 32'(b1.out_data);
           2: r = 32'(b1.out_ch);
           default: r = 32'(b1.in_ready);
         endcase
      default: case (f)
           0: r = 32'(b2.out_valid);
           1: r = 32'(b2.out_data);
           2: r = 32'(b2.out_ch);
           default: r = 32'(b2.in_ready);
         endcase
    endcase
    return r;
  endfunction

  task automatic apply();
    b0.in_data   = {din[0][3], din[0][2], din[0][1], din[0][0]};
    b0.in_valid  = vin[0];
    b0.ctrl_sel  = sel[0];
    b0.out_ready = ordy[0];
    b1.in_data   = {din[1][3], din[1][2], din[1][1], din[1][0]};
    b1.in_valid  = vin[1];
    b1.ctrl_sel  = sel[1];
    b1.out_ready = ordy[1];
    b2.in_data   = {din[2][2], din[2][1], din[2][0]};
    b2.in_valid  = vin[2][2:0];
    b2.ctrl_sel  = sel[2];
    b2.out_ready = ordy[2];
  endtask

  task automatic set_all(logic [3:0] v, logic [1:0] s, logic o);
    for (int k = 0; k < NI; k++) begin
      vin[k]  = v;
      sel[k]  = s;
      ordy[k] = o;
    end
  endtask

  task automatic rand_stim();
    for (int k = 0; k < NI; k++) begin
      for (int c = 0; c < 4; c++) din[k][c] = 8'($urandom);
      vin[k]  = 4'($urandom);
      sel[k]  = 2'($urandom);
      ordy[k] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mv[k] = 0;
      md[k] = 0;
      mc[k] = 0;
      ml[k] = nch(k) - 1;
    end
  endtask

  // Compare against the model, then move the model past the next edge
  task automatic model_step(int k);
    int n;
    int g;
    bit gv;
    bit take;
    logic [3:0] er;
    n  = nch(k);
    g  = 0;
    gv = 1'b0;
    if (is_rr(k)) begin
      for (int j = 1; j <= n; j++) begin
        int c;
        c = (ml[k] + j) % n;
        if (!gv && vin[k][c]) begin
          g  = c;
          gv = 1'b1;
        end
      end
    end else begin
      g  = (int'(sel[k]) < n) ? int'(sel[k]) : 0;
      gv = vin[k][g];
    end
    take = rst_n && (mv[k] == 0 || ordy[k]) && gv;
    er   = take ? (4'b0001 << g) : 4'b0000;
    chk($sformatf("i%0d out_valid", k), obs(k, 0), 32'(mv[k]));
    chk($sformatf("i%0d out_data", k), obs(k, 1), 32'(md[k]));
    chk($sformatf("i%0d out_ch", k), obs(k, 2), 32'(mc[k]));
    chk($sformatf("i%0d in_ready", k), obs(k, 3), 32'(er));
    if (!rst_n) begin
      mv[k] = 0;
      md[k] = 0;
      mc[k] = 0;
      ml[k] = n - 1;
    end else if (take) begin
      mv[k] = 1;
      md[k] = int'(din[k][g]);
      mc[k] = g;
      if (is_rr(k)) ml[k] = g;
    end else if (mv[k] != 0 && ordy[k]) begin
      mv[k] = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    apply();
    #1;
    for (int k = 0; k < NI; k++) model_step(k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_all(4'hF, 2'd0, 1'b1);
    apply();
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) model_step(k);
    @(negedge clk);
    set_all(4'h0, 2'd0, 1'b1);
    apply();
    rst_n = 1'b1;
  endtask

  int exp36[3] = '{1, 3, 1};

  initial begin
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < 4; c++) din[k][c] = 8'h00;
    set_all(4'h0, 2'd0, 1'b0);
    apply();
    model_reset();
    do_reset();

    // round-robin over all four channels
    set_all(4'hF, 2'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cycle();
      @(posedge clk); #1;
      chk("rr8 ch", 32'(b1.out_ch), 32'(i % 4));
      chk("rr8 valid", 32'(b1.out_valid), 32'd1);
    end

    // external select of channel 2
    set_all(4'b0100, 2'd2, 1'b1);
    din[0][2] = 8'hA5;
    cycle();
    chk("sel2 ready", 32'(b0.in_ready), 32'h4);
    @(posedge clk); #1;
    chk("sel2 valid", 32'(b0.out_valid), 32'd1);
    chk("sel2 data", 32'(b0.out_data), 32'hA5);
    chk("sel2 ch", 32'(b0.out_ch), 32'd2);

    // out-of-range select folds to channel 0
    set_all(4'b0001, 2'd3, 1'b1);
    din[2][0] = 8'h11;
    cycle();
    @(posedge clk); #1;
    chk("oor data", 32'(b2.out_data), 32'h11);
    chk("oor ch", 32'(b2.out_ch), 32'd0);

    // stall holds the word while select and data churn
    set_all(4'b0010, 2'd1, 1'b1);
    din[0][1] = 8'h3C;
    cycle();
    for (int i = 0; i < 5; i++) begin
      rand_stim();
      for (int k = 0; k < NI; k++) ordy[k] = 1'b0;
      cycle();
      chk("stall ready", 32'(b0.in_ready), 32'd0);
      @(posedge clk); #1;
      chk("stall data", 32'(b0.out_data), 32'h3C);
      chk("stall valid", 32'(b0.out_valid), 32'd1);
    end
    set_all(4'h0, 2'd0, 1'b1);
    cycle();
    @(posedge clk); #1;
    chk("drain valid", 32'(b0.out_valid), 32'd0);

    // round-robin with sparse requests
    do_reset();
    set_all(4'b1010, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      @(posedge clk); #1;
      chk("rr1010 ch", 32'(b1.out_ch), 32'(exp36[i]));
    end
    set_all(4'h0, 2'd0, 1'b1);
    cycle();
    @(posedge clk); #1;
    chk("rr1010 drain", 32'(b1.out_valid), 32'd0);

    // asynchronous reset while holding a word
    set_all(4'b0001, 2'd0, 1'b1);
    din[0][0] = 8'hFF;
    cycle();
    @(posedge clk); #1;
    chk("ar pre data", 32'(b0.out_data), 32'hFF);
    #1 rst_n = 1'b0;
    #1;
    chk("ar valid", 32'(b0.out_valid), 32'd0);
    chk("ar data", 32'(b0.out_data), 32'd0);
    chk("ar ready", 32'(b0.in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    set_all(4'h0, 2'd0, 1'b1);
    apply();
    rst_n = 1'b1;
    set_all(4'hF, 2'd0, 1'b1);
    cycle();
    @(posedge clk); #1;
    chk("ar rr first", 32'(b1.out_ch), 32'd0);
    chk("ar rr valid", 32'(b1.out_valid), 32'd1);

    repeat (400) begin
      rand_stim();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 32: data bits per channel; SHALL be >= 1.
REQ-002 Parameter NCH, default 4: input channel count; SHALL be >= 2.
REQ-003 Parameter MODE, default 0: 0 = external select, 1 = round-robin arbitration.
REQ-004 SELW = max(1, ceil(log2(NCH))), derived, not overridable.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  in  NCH  per-channel data-valid.
REQ-009 in_ready  out  NCH  per-channel accept; transfer on channel i when in_valid[i] & in_ready[i].
REQ-010 ctrl_sel  in  SELW  channel select; used only when MODE=0.
REQ-011 out_data  out  WIDTH  registered selected data.
REQ-012 out_valid  out  1  out_data holds an unconsumed word.
REQ-013 out_ready  in  1  downstream accept; transfer when out_valid & out_ready.
REQ-014 out_ch  out  SELW  index of the source channel of out_data.

Function
REQ-015 Output stage SHALL be a one-entry register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en = EMPTY | (FULL & out_ready); no input is accepted when load_en=0.
REQ-017 Grant (MODE=0): g = ctrl_sel; if ctrl_sel >= NCH, g = 0.
REQ-018 Grant (MODE=1): g = first channel with in_valid set, searching from (last_grant+1) mod NCH upward with wrap; no grant if no in_valid is set.
REQ-019 in_ready[i] SHALL be 1 only when load_en & (g==i) & in_valid[i]; at most one bit set per cycle.
REQ-020 On an input transfer: out_data <= channel g data, out_ch <= g, state -> FULL, next cycle (latency 1).
REQ-021 FULL & out_ready & no input transfer -> EMPTY; out_data and out_ch hold their values.
REQ-022 FULL & out_ready & input transfer in the same cycle -> stays FULL with new word; sustained throughput 1 word/clk.
REQ-023 FULL & !out_ready: out_data, out_ch and out_valid SHALL be stable; in_ready = 0.
REQ-024 last_grant (MODE=1) SHALL update only on an input transfer, to g.
REQ-025 MODE=0: a ctrl_sel change while FULL and stalled SHALL NOT alter the held word.
REQ-026 in_ready SHALL be combinational from in_valid, ctrl_sel, out_ready and state; out_* SHALL be registered only.

Reset
REQ-027 While rst_n=0: out_valid=0, out_data=0, out_ch=0, state=EMPTY, last_grant=NCH-1 (first round-robin grant favours channel 0).
REQ-028 in_ready SHALL be 0 while rst_n=0.
REQ-029 Reset mid-transfer SHALL discard the held word; no output transfer occurs in the reset cycle.

Structure
REQ-030 Shared package stream_mux_pkg SHALL hold MODE_SELECT=0, MODE_RR=1 and the SELW width function.
REQ-031 Round-robin search SHALL be a sub-module rr_arbiter (inputs req[NCH], last_grant; outputs grant index, grant_valid); instantiated only when MODE=1.

Verification
REQ-032 MODE=0, WIDTH=8, NCH=4, ctrl_sel=2, in_data ch2=0xA5, in_valid=0100, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=0xA5, out_ch=2.
REQ-033 MODE=0, ctrl_sel=5 with NCH=5? No; NCH=4, SELW=2 cannot exceed; use NCH=3, ctrl_sel=3, ch0=0x11 valid -> out_data=0x11, out_ch=0.
REQ-034 MODE=1, NCH=4, all in_valid=1111, out_ready=1 for 8 clocks -> out_ch sequence 0,1,2,3,0,1,2,3; one word per clock.
REQ-035 FULL with out_data=0x3C, out_ready=0 for 5 clocks while ctrl_sel and in_data toggle -> out_data=0x3C, in_ready=0000 throughout; out_ready=1 with no in_valid -> out_valid=0 next cycle.
REQ-036 MODE=1, in_valid=1010 after reset -> first grant ch1, then ch3, then ch1; in_valid=0000 -> out_valid drops after last drain.
REQ-037 rst_n low asynchronously while FULL (out_data=0xFF) -> out_valid=0, out_data=0 immediately, without waiting for a clock edge; after release, MODE=1 first grant is ch0 when all valid.
